obc_shift_accum: RTL and testbench



---
 rtl/obc_shift_accum_pkg.sv | 20 ++
 rtl/obc_shift_accum_if.sv | 35 +++
 rtl/obc_shift_accum_bit_counter.sv | 48 ++++
 rtl/obc_shift_accum.sv | 145 ++++++++++++++
 tb/tb_obc_shift_accum.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/obc_shift_accum_pkg.sv
// Shared definitions for the OBC bit-serial shift-accumulator:
// default widths, controller state encoding and a counter-width helper.
package obc_shift_accum_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ROM_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the bit-position counter; a single-slice transform still
    // needs a one-bit index.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obc_shift_accum_if.sv
// Bundle of the start/result handshake and the ROM-stage side-band
// (bit index, sign-invert line, partial sum) of the shift-accumulator.
interface obc_shift_accum_if
    import obc_shift_accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROM_W  = DEF_ROM_W,
    parameter int OUT_W  = ROM_W + DATA_W
);
    localparam int CNT_W = cnt_width(DATA_W);

    logic             start;
    logic             in_ready;
    logic [ROM_W-1:0] offset;
    logic [CNT_W-1:0] bit_idx;
    logic             m;
    logic [ROM_W-1:0] romout;
    logic             busy;
    logic [OUT_W-1:0] y;
    logic             out_valid;
    logic             out_ready;

    // The accumulator block.
    modport slave (
        input  start, offset, romout, out_ready,
        output in_ready, bit_idx, m, busy, y, out_valid
    );

    // Whoever issues transforms, supplies partial sums and consumes results.
    modport master (
        output start, offset, romout, out_ready,
        input  in_ready, bit_idx, m, busy, y, out_valid
    );

endinterface

// File: rtl/obc_shift_accum_bit_counter.sv
// Loadable down-counter that walks bit positions MSB-first and flags the
// MSB position and the terminal (LSB) position.
module obc_shift_accum_bit_counter
    import obc_shift_accum_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    localparam int CNT_W  = cnt_width(DATA_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             msb_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load the MSB position, or step down towards zero and park there.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_MAX;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks so all registers update together at the edge.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign msb_o = (cnt_q == CNT_MAX);
    assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/obc_shift_accum.sv
// Bit-serial controller and Horner shift-accumulator for one OBC DFT output
// component. Sequences bit slices MSB-first to the upstream selector, flags
// the MSB slice to the ROM stage, accumulates the partial sums, adds the
// offset constant and hands one result per transform downstream.
module obc_shift_accum
    import obc_shift_accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROM_W  = DEF_ROM_W,
    parameter int OUT_W  = ROM_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    obc_shift_accum_if.slave   bus
);

    localparam int CNT_W = cnt_width(DATA_W);

    state_e           state_q;
    state_e           state_d;

    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_d;
    logic [ROM_W-1:0] off_q;
    logic [ROM_W-1:0] off_d;
    logic [OUT_W-1:0] y_q;
    logic [OUT_W-1:0] y_d;

    logic [CNT_W-1:0] cnt;
    logic             cnt_msb;
    logic             cnt_tc;
    logic             cnt_load;
    logic             cnt_dec;

    logic             in_run;
    logic             accept;
    logic [OUT_W-1:0] rom_ext;
    logic [OUT_W-1:0] off_ext;
    logic [OUT_W-1:0] acc_step;

    obc_shift_accum_bit_counter #(
        .DATA_W (DATA_W)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .cnt_o  (cnt),
        .msb_o  (cnt_msb),
        .tc_o   (cnt_tc)
    );

    // Partial sums and the offset are two's complement; widen with sign.
    assign rom_ext  = OUT_W'($signed(bus.romout));
    assign off_ext  = OUT_W'($signed(off_q));
    assign acc_step = (acc_q << 1) + rom_ext;

    assign in_run = (state_q == ST_RUN);
    assign accept = (state_q == ST_IDLE) && bus.start;

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE -> RUN on start, RUN -> DONE after the LSB slice,
    // DONE -> IDLE once the result is taken. start outside IDLE is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start)     state_d = ST_RUN;
            ST_RUN:  if (cnt_tc)        state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Outputs and counter controls decoded from the current state.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        bus.m         = 1'b0;
        bus.bit_idx   = '0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                cnt_load     = bus.start;
            end
            ST_RUN: begin
                bus.busy    = 1'b1;
                bus.bit_idx = cnt;
                bus.m       = cnt_msb;
                cnt_dec     = 1'b1;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    // Datapath next values: latch the offset and clear the sum on accept,
    // shift-accumulate each RUN slice, capture the final sum plus offset
    // on the LSB slice. y holds until the next transform completes.
    always_comb begin
        acc_d = acc_q;
        off_d = off_q;
        y_d   = y_q;
        if (accept) begin
            off_d = bus.offset;
            acc_d = '0;
        end
        if (in_run) begin
            acc_d = acc_step;
            if (cnt_tc) begin
                y_d = acc_step + off_ext;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            off_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            off_q <= off_d;
            y_q   <= y_d;
        end
    end

    assign bus.y = y_q;

endmodule

// File: tb/tb_obc_shift_accum.sv
// Randomized self-checking bench for obc_shift_accum. The ROM stage is a
// table indexed by bit_idx; expected results come from the closed form
// y = offset + sum_k romout[k] * 2^k, evaluated in 64-bit arithmetic.
module tb_obc_shift_accum;

    localparam int DW  = 16;
    localparam int RW  = 32;
    localparam int OW  = RW + DW;
    localparam int PER = DW + 2;
    localparam int NB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    obc_shift_accum_if #(.DATA_W(DW), .ROM_W(RW), .OUT_W(OW)) bus ();

    obc_shift_accum #(.DATA_W(DW), .ROM_W(RW), .OUT_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational ROM stage: partial sum for whatever slice is selected.
    int rom_tab [DW];
    assign bus.romout = rom_tab[bus.bit_idx];

    int n_checks = 0;
    int n_errors = 0;

    logic [OW-1:0] held_y;
    int            offs_hist [NB*PER];
    int            bad;
    int            offs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] ref_y(input int offset_v);
        longint s = longint'(offset_v);
        for (int k = 0; k < DW; k++) begin
            s += longint'(rom_tab[k]) * (longint'(1) << k);
        end
        return OW'(s);
    endfunction

    task automatic fill_rom(input int v);
        for (int k = 0; k < DW; k++) rom_tab[k] = v;
    endtask

    task automatic fill_rom_random();
        for (int k = 0; k < DW; k++) rom_tab[k] = $urandom;
    endtask

    // Called at a negedge with the DUT idle. Issues one transform, watches
    // the slice sequence, latency and final value. With pulse_mid, start is
    // re-asserted with a different offset mid-RUN; it must be ignored.
    task automatic run_xfer(input int offset_v, input bit pulse_mid, input string tag);
        int            lat;
        int            nbad;
        logic [OW-1:0] exp_y;
        lat   = -1;
        nbad  = 0;
        exp_y = ref_y(offset_v);
        bus.offset = offset_v;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4 * DW; i++) begin
            if (bus.out_valid === 1'b1) begin
                lat = i;
                break;
            end
            if ((int'(bus.bit_idx) != DW - 1 - i) || (bus.m !== (i == 0)) ||
                (bus.busy !== 1'b1) || (bus.in_ready !== 1'b0)) begin
                nbad++;
            end
            if (pulse_mid && i == 5) begin
                bus.start  = 1'b1;
                bus.offset = ~offset_v;
            end else if (pulse_mid && i == 6) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(DW));
        check({tag, "_slices"}, 64'(nbad), 64'd0);
        check({tag, "_y"}, 64'(bus.y), 64'(exp_y));
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_to_idle"}, 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        bus.offset    = '0;
        fill_rom(0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("reset_flags", 64'({bus.in_ready, bus.busy, bus.out_valid, bus.m}), 64'(4'b1000));
        check("reset_y", 64'(bus.y), 64'd0);
        check("reset_bit_idx", 64'(bus.bit_idx), 64'd0);

        // All-ones partial sums: 2^16 - 1.
        fill_rom(1);
        run_xfer(0, 1'b0, "ones");
        check("ones_const", 64'(bus.y), 64'd65535);
        release_result("ones");

        // All minus-one partial sums.
        fill_rom(-1);
        run_xfer(0, 1'b0, "neg");
        check("neg_const", 64'(bus.y), 64'h0000_FFFF_FFFF_0001);
        release_result("neg");

        // Only the MSB slice contributes, negative offset.
        fill_rom(0);
        rom_tab[DW-1] = 5;
        run_xfer(-100, 1'b0, "msb");
        check("msb_const", 64'(bus.y), 64'd163740);
        release_result("msb");

        // Result held under back-pressure; start in RUN and DONE ignored.
        fill_rom_random();
        offs = $urandom;
        run_xfer(offs, 1'b1, "hold");
        held_y = bus.y;
        bad    = 0;
        for (int i = 0; i < 10; i++) begin
            bus.start = (i % 3 == 1);
            @(negedge clk);
            if ((bus.out_valid !== 1'b1) || (bus.y !== held_y) ||
                (bus.in_ready !== 1'b0) || (bus.busy !== 1'b0)) begin
                bad++;
            end
        end
        check("hold_stable", 64'(bad), 64'd0);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("hold_release", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
        @(negedge clk);
        check("hold_no_restart", 64'({bus.in_ready, bus.busy}), 64'(2'b10));

        // Asynchronous reset in the 5th RUN cycle.
        fill_rom(3);
        bus.offset = 7;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_rst_flags", 64'({bus.in_ready, bus.busy, bus.out_valid, bus.m}), 64'(4'b1000));
        check("midrun_rst_y", 64'(bus.y), 64'd0);
        check("midrun_rst_bit_idx", 64'(bus.bit_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_rom(1);
        run_xfer(0, 1'b0, "after_rst");
        check("after_rst_const", 64'(bus.y), 64'd65535);
        release_result("after_rst");

        // Randomized transforms with random back-pressure.
        for (int t = 0; t < 12; t++) begin
            fill_rom_random();
            offs = $urandom;
            run_xfer(offs, t[0], $sformatf("rand%0d", t));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_result($sformatf("rand%0d", t));
        end

        // Back-to-back: start and out_ready held high, offset changing every
        // cycle. Accepts land every PER edges; each result uses the offset
        // present at its own accept edge.
        fill_rom_random();
        bad           = 0;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < NB * PER; c++) begin
            offs_hist[c] = $urandom;
            bus.offset   = offs_hist[c];
            @(negedge clk);
            if (c % PER == DW) begin
                if (bus.out_valid !== 1'b1) bad++;
                check($sformatf("b2b_y%0d", c / PER), 64'(bus.y), 64'(ref_y(offs_hist[c - DW])));
            end else if (bus.out_valid !== 1'b0) begin
                bad++;
            end
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_valid_timing", 64'(bad), 64'd0);
        @(negedge clk);
        check("b2b_end_idle", 64'({bus.in_ready, bus.busy, bus.out_valid}), 64'(3'b100));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
